mdu_divider: RTL and testbench

Multi-cycle 32-bit integer divider for the MIPS datapath, executing DIV and DIVU beside the combinational ALU. It runs a restoring shift-subtract loop, one quotient bit per clock, and returns the quotient (LO) and remainder (HI). Control uses a start/busy/done handshake, so the pipeline stalls on `busy` and writes HI/LO on `done`.

---
 rtl/mdu_divider.sv | 153 +++++++++++++++
 tb/tb_mdu_divider.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_divider.sv
// mdu_divider: multi-cycle restoring divider for DIV / DIVU.
// Produces one quotient bit per clock on magnitudes, then applies the
// sign fix-up and divide-by-zero results in a single FIX cycle. Latency
// is fixed regardless of operand values.
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic             sign_mode;
    logic             dividend_neg;
    logic             divisor_neg;
    logic             zero_divisor;
    logic [WIDTH-1:0] raw_dividend;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] dividend_reg;
    logic [WIDTH-1:0] part_rem;
    logic [CW-1:0]    count;

    logic             accept;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH-1:0] quot_signed;
    logic [WIDTH-1:0] rem_signed;

    // Operand magnitudes, trial subtract and sign fix-up values
    always_comb begin
        accept       = (state == IDLE) && start;
        dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        shifted_rem  = {part_rem, dividend_reg[WIDTH-1]};
        trial        = shifted_rem - {1'b0, divisor_mag};
        trial_ok     = ~trial[WIDTH];
        quot_signed  = (sign_mode && (dividend_neg ^ divisor_neg)) ? -dividend_reg : dividend_reg;
        rem_signed   = (sign_mode && dividend_neg) ? -part_rem : part_rem;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST_ITER) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture and shift-subtract iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_mode    <= 1'b0;
            dividend_neg <= 1'b0;
            divisor_neg  <= 1'b0;
            zero_divisor <= 1'b0;
            raw_dividend <= '0;
            divisor_mag  <= '0;
            dividend_reg <= '0;
            part_rem     <= '0;
            count        <= '0;
        end else if (accept) begin
            sign_mode    <= is_signed;
            dividend_neg <= is_signed && dividend[WIDTH-1];
            divisor_neg  <= is_signed && divisor[WIDTH-1];
            zero_divisor <= (divisor == '0);
            raw_dividend <= dividend;
            divisor_mag  <= divisor_abs;
            dividend_reg <= dividend_abs;
            part_rem     <= '0;
            count        <= '0;
        end else if (state == RUN) begin
            dividend_reg <= {dividend_reg[WIDTH-2:0], trial_ok};
            part_rem     <= trial_ok ? trial[WIDTH-1:0] : shifted_rem[WIDTH-1:0];
            count        <= count + CW'(1);
        end
    end

    // Result registers, loaded once per operation in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == FIX) begin
            if (zero_divisor) begin
                quotient    <= '1;
                remainder   <= raw_dividend;
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= quot_signed;
                remainder   <= rem_signed;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mdu_divider.sv
// tb_mdu_divider: scoreboard bench for mdu_divider. Expected results are
// queued when an operation is launched and popped when done pulses.
module tb_mdu_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } result_t;

    result_t expq[$];
    int totalChecks = 0;
    int failChecks  = 0;
    int doneSeen    = 0;

    mdu_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            failChecks++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model used for the randomised operations
    task automatic model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output result_t res);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        if (b == 0) begin
            res.q = '1;
            res.r = a;
            res.z = 1'b1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res.q = 32'h8000_0000;
            res.r = '0;
            res.z = 1'b0;
        end else if (sgn) begin
            res.q = sa / sb;
            res.r = sa % sb;
            res.z = 1'b0;
        end else begin
            res.q = a / b;
            res.r = a % b;
            res.z = 1'b0;
        end
    endtask

    // Scoreboard: compare results whenever done pulses
    always @(negedge clk) begin
        if (done) begin
            result_t e;
            doneSeen++;
            if (expq.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                checkOutput("quotient", quotient, e.q);
                checkOutput("remainder", remainder, e.r);
                checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
            end
        end
    end

    // Launch one operation and track its handshake timing.
    // injectAt > 0 pulses a stray start mid-run; resetAt > 0 aborts with reset.
    task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input result_t exp, input int injectAt, input int resetAt);
        int n;
        int busyCnt;
        int savedDone;
        expq.push_back(exp);
        @(negedge clk);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        busyCnt = 0;
        while (n < 60) begin
            @(negedge clk);
            if (done) break;
            if (busy) busyCnt++;
            n++;
            if (injectAt > 0 && n == injectAt) begin
                start     = 1'b1;
                is_signed = 1'b1;
                dividend  = 32'd777;
                divisor   = 32'd2;
            end
            if (injectAt > 0 && n == injectAt + 1) begin
                start = 1'b0;
            end
            if (resetAt > 0 && n == resetAt) begin
                savedDone = doneSeen;
                rst_n = 1'b0;
                #1;
                checkOutput("abort_quotient", quotient, 32'd0);
                checkOutput("abort_remainder", remainder, 32'd0);
                checkOutput("abort_dbz", {31'd0, div_by_zero}, 32'd0);
                checkOutput("abort_busy", {31'd0, busy}, 32'd0);
                void'(expq.pop_back());
                @(negedge clk);
                rst_n = 1'b1;
                repeat (40) @(negedge clk);
                checkOutput("abort_no_done", doneSeen, savedDone);
                return;
            end
        end
        if (n >= 60) begin
            checkOutput("timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput("latency", n, 32'd33);
        checkOutput("busy_cycles", busyCnt, 32'd33);
        checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("done_pulse", {31'd0, done}, 32'd0);
        checkOutput("hold_quotient", quotient, exp.q);
        checkOutput("hold_remainder", remainder, exp.r);
    endtask

    function automatic result_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
        result_t t;
        t.q = q;
        t.r = r;
        t.z = z;
        return t;
    endfunction

    // Main sequence
    initial begin
        result_t e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic sgn;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_quotient", quotient, 32'd0);
        checkOutput("reset_remainder", remainder, 32'd0);
        checkOutput("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0), 0, 0);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0), 0, 0);
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, mk(32'hFFFF_FFFD, 32'd1, 1'b0), 0, 0);
        applyStimulus(1'b0, 32'h0000_1234, 32'd0, mk(32'hFFFF_FFFF, 32'h0000_1234, 1'b1), 0, 0);
        applyStimulus(1'b0, 32'd9, 32'd3, mk(32'd3, 32'd0, 1'b0), 0, 0);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'd0, 1'b0), 0, 0);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, mk(32'hFFFF_FFFF, 32'd0, 1'b0), 0, 0);
        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd0, mk(32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1), 0, 0);
        applyStimulus(1'b0, 32'd50, 32'd5, mk(32'd10, 32'd0, 1'b0), 11, 0);
        applyStimulus(1'b0, 32'd1000, 32'd3, mk(32'd333, 32'd1, 1'b0), 0, 16);
        applyStimulus(1'b0, 32'd1000, 32'd3, mk(32'd333, 32'd1, 1'b0), 0, 0);

        for (int i = 0; i < 6; i++) begin
            sgn = $urandom_range(0, 1);
            a   = $urandom;
            b   = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (sgn && (i % 3 == 0)) b = -b;
            model(sgn, a, b, e);
            applyStimulus(sgn, a, b, e, 0, 0);
        end

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", expq.size(), 32'd0);
        $display("%0d/%0d checks passed", totalChecks - failChecks, totalChecks);
        $finish;
    end

endmodule
